// File: rtl/locked_common_memory_pkg.sv
// -----------------------------------------------------------------------------
// locked_mem_pkg
// Shared types for the locked common memory: operation codes, controller
// states, requester IDs and the per-word lock entry.
// Optional feature macro: LOCKED_MEM_BYTE_EN_EN (byte strobes, see top).
// -----------------------------------------------------------------------------
package locked_mem_pkg;

    typedef enum logic [1:0] {
        READ         = 2'b00,
        WRITE        = 2'b01,
        LOCK_READ    = 2'b10,
        UNLOCK_WRITE = 2'b11
    } mem_op_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     locked;
        port_id_e owner;
    } lock_entry_t;

    localparam lock_entry_t LOCK_FREE = '{locked: 1'b0, owner: PORT_A};

    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/locked_common_memory_if.sv
// -----------------------------------------------------------------------------
// locked_mem_port_if
// One requester port of the locked common memory.
//   master : the core load/store unit (drives request, receives response)
//   slave  : the memory (accepts request, returns response)
// Signals: req_valid/req_ready handshake, op, addr, wdata, optional wstrb
// (LOCKED_MEM_BYTE_EN_EN), and the registered response rsp_valid/rdata/err.
// -----------------------------------------------------------------------------
interface locked_mem_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    import locked_mem_pkg::*;

    logic                req_valid;
    logic                req_ready;
    mem_op_e             op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
`ifdef LOCKED_MEM_BYTE_EN_EN
    logic [DATA_W/8-1:0] wstrb;
`endif
    logic                rsp_valid;
    logic [DATA_W-1:0]   rdata;
    logic                err;

    modport master (
`ifdef LOCKED_MEM_BYTE_EN_EN
        output wstrb,
`endif
        output req_valid, op, addr, wdata,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
`ifdef LOCKED_MEM_BYTE_EN_EN
        input  wstrb,
`endif
        input  req_valid, op, addr, wdata,
        output req_ready, rsp_valid, rdata, err
    );

endinterface

// File: rtl/locked_common_memory_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// Two-requester round-robin arbiter. Grants are combinational; the priority
// pointer only moves when both requesters contend, so an uncontested grant
// leaves it where it was.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointer -> PORT_A)
//   en            : grants allowed this cycle
//   req_a, req_b  : request inputs
//   gnt_a, gnt_b  : one-hot (or zero) grant outputs
// -----------------------------------------------------------------------------
module mem_rr_arbiter
    import locked_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    port_id_e prio_q, prio_d;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        gnt_a  = en && req_a && (!req_b || prio_q == PORT_A);
        gnt_b  = en && req_b && (!req_a || prio_q == PORT_B);
        prio_d = prio_q;
        if (gnt_a && req_b) prio_d = other_port(PORT_A);
        if (gnt_b && req_a) prio_d = other_port(PORT_B);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) prio_q <= PORT_A;
        else     prio_q <= prio_d;
    end

endmodule

// File: rtl/locked_common_memory.sv
// -----------------------------------------------------------------------------
// locked_common_memory
// Two-port shared word memory with per-word hardware locks. Ports A and B are
// arbitrated round-robin, one access per cycle; each word has a lock bit and
// an owner ID supporting atomic LOCK_READ / UNLOCK_WRITE. After reset an INIT
// sweep clears data and locks one word per cycle before requests are served.
// Optional feature macro: LOCKED_MEM_BYTE_EN_EN -- adds per-port wstrb; WRITE
// and UNLOCK_WRITE then update only strobed bytes (lock action still applies
// with a zero strobe).
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   init_done  : high once the clear sweep has finished
//   a_port     : requester port A (slave side of locked_mem_port_if)
//   b_port     : requester port B (slave side of locked_mem_port_if)
// -----------------------------------------------------------------------------
module locked_common_memory
    import locked_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    locked_mem_port_if.slave    a_port,
    locked_mem_port_if.slave    b_port
);

    // Storage
    // NOTE: the arrays have no reset; the INIT sweep clears them one word
    // per cycle, which keeps them mappable onto plain RAM.
    logic [DATA_W-1:0] data_mem [DEPTH];
    lock_entry_t       lock_mem [DEPTH];

    // Controller state
    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              init_done_q, init_done_d;

    // Registered responses
    logic              a_rsp_valid_q, a_rsp_valid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic              a_err_q, a_err_d;
    logic              b_rsp_valid_q, b_rsp_valid_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              b_err_q, b_err_d;

    // Arbitration
    logic gnt_a, gnt_b;
    logic run_en;

    assign run_en = (state_q == RUN) && !rst;

    mem_rr_arbiter u_arbiter (
        .clk   (clk),
        .rst   (rst),
        .en    (run_en),
        .req_a (a_port.req_valid),
        .req_b (b_port.req_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_port.req_ready = gnt_a;
    assign b_port.req_ready = gnt_b;

    // Selected request
    logic              accept;
    port_id_e          req_port;
    mem_op_e           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
`ifdef LOCKED_MEM_BYTE_EN_EN
    logic [DATA_W/8-1:0] req_wstrb;
`endif

    assign accept    = gnt_a || gnt_b;
    assign req_port  = gnt_b ? PORT_B : PORT_A;
    assign req_op    = gnt_b ? b_port.op    : a_port.op;
    assign req_addr  = gnt_b ? b_port.addr  : a_port.addr;
    assign req_wdata = gnt_b ? b_port.wdata : a_port.wdata;
`ifdef LOCKED_MEM_BYTE_EN_EN
    assign req_wstrb = gnt_b ? b_port.wstrb : a_port.wstrb;
`endif

    // Current word and lock check
    logic [DATA_W-1:0] cur_data;
    lock_entry_t       cur_lock;
    logic              blocked;
    logic [DATA_W-1:0] merged_data;

    assign cur_data = data_mem[req_addr];
    assign cur_lock = lock_mem[req_addr];
    assign blocked  = cur_lock.locked && (cur_lock.owner != req_port);

`ifdef LOCKED_MEM_BYTE_EN_EN
    always_comb begin
        merged_data = cur_data;
        for (int i = 0; i < DATA_W/8; i++) begin
            if (req_wstrb[i]) merged_data[i*8 +: 8] = req_wdata[i*8 +: 8];
        end
    end
`else
    assign merged_data = req_wdata;
`endif

    // Write port of the storage (shared by sweep and RUN accesses)
    logic              data_we;
    logic              lock_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    lock_entry_t       wr_lock;

    // Response of the current access
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        init_done_d   = init_done_q;
        data_we       = 1'b0;
        lock_we       = 1'b0;
        wr_addr       = req_addr;
        wr_data       = merged_data;
        wr_lock       = LOCK_FREE;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        a_rsp_valid_d = 1'b0;
        a_rdata_d     = '0;
        a_err_d       = 1'b0;
        b_rsp_valid_d = 1'b0;
        b_rdata_d     = '0;
        b_err_d       = 1'b0;

        unique case (state_q)
            INIT: begin
                data_we = 1'b1;
                lock_we = 1'b1;
                wr_addr = sweep_q;
                wr_data = '0;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    unique case (req_op)
                        READ: begin
                            rsp_rdata = cur_data;
                        end
                        WRITE: begin
                            if (blocked) rsp_err = 1'b1;
                            else         data_we = 1'b1;
                        end
                        LOCK_READ: begin
                            if (blocked) begin
                                rsp_err = 1'b1;
                            end else begin
                                rsp_rdata = cur_data;
                                lock_we   = 1'b1;
                                wr_lock   = '{locked: 1'b1, owner: req_port};
                            end
                        end
                        UNLOCK_WRITE: begin
                            // Only the owner of a locked word may unlock it.
                            if (blocked || !cur_lock.locked) begin
                                rsp_err = 1'b1;
                            end else begin
                                data_we = 1'b1;
                                lock_we = 1'b1;
                            end
                        end
                        default: ;
                    endcase

                    if (req_port == PORT_A) begin
                        a_rsp_valid_d = 1'b1;
                        a_rdata_d     = rsp_rdata;
                        a_err_d       = rsp_err;
                    end else begin
                        b_rsp_valid_d = 1'b1;
                        b_rdata_d     = rsp_rdata;
                        b_err_d       = rsp_err;
                    end
                end
            end
            default: ;
        endcase

        // No storage update while reset is held.
        if (rst) begin
            data_we = 1'b0;
            lock_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[wr_addr] <= wr_data;
        if (lock_we) lock_mem[wr_addr] <= wr_lock;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INIT;
            sweep_q       <= '0;
            init_done_q   <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            a_rdata_q     <= '0;
            a_err_q       <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            b_rdata_q     <= '0;
            b_err_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            init_done_q   <= init_done_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            a_rdata_q     <= a_rdata_d;
            a_err_q       <= a_err_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            b_rdata_q     <= b_rdata_d;
            b_err_q       <= b_err_d;
        end
    end

    // A response still in its output register when rst rises is dropped
    // immediately rather than one cycle later.
    assign init_done        = init_done_q;
    assign a_port.rsp_valid = a_rsp_valid_q && !rst;
    assign a_port.rdata     = rst ? '0 : a_rdata_q;
    assign a_port.err       = a_err_q && !rst;
    assign b_port.rsp_valid = b_rsp_valid_q && !rst;
    assign b_port.rdata     = rst ? '0 : b_rdata_q;
    assign b_port.err       = b_err_q && !rst;

endmodule
